// File: rtl/pixel_writer.sv
// pixel_writer
//   Buffers rasteriser pixel writes in a small FIFO and drains them to the
//   frame-buffer memory with a valid/ack handshake. At the end of a frame it
//   flushes the buffer and pulses 'finished'.
//
//   The FIFO head is the entry currently presented to memory. It stays in the
//   FIFO, and so counts toward occupancy, until memory acknowledges it. This
//   keeps the address and data stable under backpressure and lets a pixel
//   strobed into an idle writer appear on the memory port on the next cycle.
//
// Optional feature (macro PIXEL_WRITER_CLIP_EN):
//   When defined, pixels with pixel_number >= FRAME_PIXELS are discarded at
//   the input. They are never buffered, never counted, and never set overflow.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   pixel_ready  in   strobe: pixel_number/rgba valid this cycle
//   pixel_number in   [18:0] linear pixel address
//   rgba         in   [31:0] pixel colour
//   frame_ready  in   strobe: frame complete, flush then report
//   mem_ack      in   memory accepts the current write
//   mem_write    out  write request
//   mem_addr     out  [18:0] write address
//   mem_data     out  [31:0] write data
//   finished     out  one-cycle pulse when the frame has been written
//   fifo_full    out  FIFO holds FIFO_DEPTH entries
//   overflow     out  sticky: a pixel was dropped on a full FIFO
//   pixel_count  out  [18:0] pixels written in this frame (saturating)
module pixel_writer #(
  parameter int FIFO_DEPTH     = 8,
  parameter int LOG_FIFO_DEPTH = 3,
  parameter int FRAME_PIXELS   = 307200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixel_ready,
  input  logic [18:0] pixel_number,
  input  logic [31:0] rgba,
  input  logic        frame_ready,
  input  logic        mem_ack,
  output logic        mem_write,
  output logic [18:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        finished,
  output logic        fifo_full,
  output logic        overflow,
  output logic [18:0] pixel_count
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  localparam logic [LOG_FIFO_DEPTH:0] DEPTH_C = (LOG_FIFO_DEPTH+1)'(FIFO_DEPTH);
  localparam logic [LOG_FIFO_DEPTH:0] ONE_C   = (LOG_FIFO_DEPTH+1)'(1);

  state_t                    state_q, state_d;
  logic [LOG_FIFO_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_FIFO_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_FIFO_DEPTH:0]   count_q, count_d;
  logic                      flush_q, flush_d;
  logic                      overflow_q, overflow_d;
  logic [18:0]               pixcnt_q, pixcnt_d;

  logic [50:0] fifo_mem [FIFO_DEPTH];
  logic [50:0] head;
  logic        accept, push, pop, drop, full, empty;

  function automatic logic [18:0] sat_inc(input logic [18:0] v);
    return (v == '1) ? v : v + 19'd1;
  endfunction

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign head  = fifo_mem[rd_ptr_q];

`ifdef PIXEL_WRITER_CLIP_EN
  localparam logic [18:0] CLIP_LIMIT = 19'(FRAME_PIXELS);
  assign accept = pixel_ready && (pixel_number < CLIP_LIMIT);
`else
  assign accept = pixel_ready;
`endif

  // Retiring the head frees a slot in the same cycle, so a full FIFO can
  // still take a new pixel while memory acknowledges.
  assign pop  = (state_q == WRITE) && mem_ack;
  assign push = accept && (!full || pop);
  assign drop = accept && full && !pop;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pixcnt_d   = pixcnt_q;
    overflow_d = overflow_q || drop;
    flush_d    = flush_q || frame_ready;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + ONE_C;
    else if (pop && !push) count_d = count_q - ONE_C;

    case (state_q)
      IDLE: begin
        // Pending entries are drained before the flush is reported; a pixel
        // arriving after frame_ready waits for the next frame.
        if (!empty)       state_d = WRITE;
        else if (flush_q) state_d = DONE;
        else if (push)    state_d = WRITE;
      end
      WRITE: begin
        if (mem_ack) begin
          pixcnt_d = sat_inc(pixcnt_q);
          if (count_q > ONE_C) state_d = WRITE;
          else if (flush_q)    state_d = DONE;
          else if (push)       state_d = WRITE;
          else                 state_d = IDLE;
        end
      end
      DONE: begin
        // A frame_ready landing here arms the next frame.
        flush_d  = frame_ready;
        pixcnt_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
      overflow_q <= 1'b0;
      pixcnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      flush_q    <= flush_d;
      overflow_q <= overflow_d;
      pixcnt_q   <= pixcnt_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {pixel_number, rgba};
  end

  // Address/data are gated so the memory port reads zero outside WRITE.
  assign mem_write   = (state_q == WRITE);
  assign mem_addr    = mem_write ? head[50:32] : '0;
  assign mem_data    = mem_write ? head[31:0]  : '0;
  assign finished    = (state_q == DONE);
  assign fifo_full   = full;
  assign overflow    = overflow_q;
  assign pixel_count = pixcnt_q;

endmodule

// File: doc/pixel_writer.md
PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 Parameter FIFO_DEPTH, 8, number of buffered pixel entries (power of two).
REQ-002 Parameter LOG_FIFO_DEPTH, 3, log2(FIFO_DEPTH), width of FIFO pointers.
REQ-003 Parameter FRAME_PIXELS, 307200, number of valid addresses in a 640x480 frame.
REQ-004 clk  input  1  the single clock; all logic is rising-edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pixel_ready  input  1  one-cycle strobe; pixel_number and rgba are valid this cycle.
REQ-007 pixel_number  input  19  linear pixel address from the rasteriser (640*y + x).
REQ-008 rgba  input  32  colour for the strobed pixel.
REQ-009 frame_ready  input  1  one-cycle strobe; the current frame is complete, flush and report.
REQ-010 mem_ack  input  1  frame-buffer memory accepts the current write this cycle.
REQ-011 mem_write  output  1  write request to frame-buffer memory.
REQ-012 mem_addr  output  19  write address, equal to the buffered pixel_number.
REQ-013 mem_data  output  32  write data, equal to the buffered rgba.
REQ-014 finished  output  1  one-cycle pulse; all pixels of the frame are written.
REQ-015 fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-016 overflow  output  1  sticky flag; a pixel was dropped because the FIFO was full.
REQ-017 pixel_count  output  19  pixels written to memory in the current frame.

Function
REQ-018 Each cycle with pixel_ready=1 and the FIFO not full, the block SHALL push {pixel_number, rgba}.
REQ-019 Each cycle with pixel_ready=1 and the FIFO full, the block SHALL drop the pixel and set overflow.
REQ-020 The block SHALL accept a push and a pop in the same cycle, with occupancy unchanged, including when full.
REQ-021 The FSM SHALL have states IDLE, WRITE and DONE.
REQ-022 IDLE, FIFO non-empty: on the next edge, load the head into mem_addr/mem_data, pop it, and go to WRITE.
REQ-023 IDLE, FIFO empty, flush_pending=1: go to DONE.
REQ-024 WRITE: mem_write SHALL be 1, with mem_addr/mem_data held stable until a cycle with mem_ack=1.
REQ-025 WRITE with mem_ack=1: increment pixel_count; if the FIFO is non-empty, load and pop the next head and stay in WRITE (back-to-back, no bubble).
REQ-026 WRITE with mem_ack=1 and the FIFO empty: go to DONE if flush_pending=1, else go to IDLE.
REQ-027 DONE: pulse finished=1 for exactly one cycle, clear flush_pending, clear pixel_count, and return to IDLE.
REQ-028 The minimum latency from the pixel_ready edge to mem_write=1 SHALL be one cycle.
REQ-029 frame_ready SHALL set flush_pending, which holds until DONE.
REQ-030 A pixel strobed in the same cycle as frame_ready SHALL belong to the frame being flushed.
REQ-031 frame_ready arriving in DONE SHALL re-arm flush_pending for the next frame; it SHALL NOT be lost.
REQ-032 pixel_ready accepted during WRITE or DONE SHALL be buffered normally.
REQ-033 mem_ack outside WRITE SHALL be ignored.
REQ-034 pixel_count SHALL saturate at 2^19-1.

Reset
REQ-035 While reset=1: state=IDLE; FIFO empty; pointers 0; flush_pending=0.
REQ-036 While reset=1, every output SHALL be 0 (mem_write, mem_addr, mem_data, finished, fifo_full, overflow, pixel_count).
REQ-037 Reset asserted mid-write SHALL abandon the write and discard all buffered pixels; there is no resumption.

Configuration
REQ-038 With macro PIXEL_WRITER_CLIP_EN defined, a pixel with pixel_number >= FRAME_PIXELS SHALL be discarded at input: never pushed, no overflow, not counted.
REQ-039 Without PIXEL_WRITER_CLIP_EN, every pixel SHALL be pushed regardless of address.

Verification
REQ-040 Single pixel: pixel 1000, rgba 0xFF00FF80, mem_ack tied 1 -> next cycle mem_write=1, addr 1000, data 0xFF00FF80; pixel_count=1.
REQ-041 Backpressure: 3 pixels (addr 5,6,7), mem_ack low 10 cycles then high -> addr 5 held stable 10 cycles, then writes 5,6,7 on consecutive cycles.
REQ-042 Overflow: mem_ack=0, 9 strobes with FIFO_DEPTH=8 -> fifo_full=1 after the 8th, overflow=1 after the 9th; ack release -> exactly 8 writes.
REQ-043 Flush: 4 pixels, frame_ready in the same cycle as the 4th -> finished pulses once after the 4th ack, then pixel_count=0.
REQ-044 Clip: pixel_number 307200 with PIXEL_WRITER_CLIP_EN -> no mem_write; without the macro -> one write to addr 307200.
REQ-045 Reset mid-write: 2 pixels buffered, mem_write=1, reset pulse -> all outputs 0; no writes after release until new pixel_ready.
